// File: rtl/stack_pkg.sv
// Shared types for the LIFO register stack: operation encoding and its decode.
package stack_pkg;

   typedef enum logic [1:0] {
      OP_NOP     = 2'b00,
      OP_POP     = 2'b01,
      OP_PUSH    = 2'b10,
      OP_REPLACE = 2'b11
   } stack_op_t;

   function automatic stack_op_t decode_op(input logic push, input logic pop);
      return stack_op_t'({push, pop});
   endfunction

endpackage

// File: rtl/stack_mem.sv
// DEPTH x n backing store: one synchronous write port, one asynchronous read port.
module stack_mem #(
   parameter int n     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [n-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [n-1:0]             rdata
);

   logic [n-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stack_register.sv
// LIFO register stack: registered top-of-stack, entry count and sticky error flags.
module stack_register
   import stack_pkg::*;
#(
   parameter int n     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [n-1:0]               data,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clr_err,
   output logic [n-1:0]               dataOut,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   stack_op_t       op;
   logic [CW-1:0]   next_count;
   logic [n-1:0]    next_top;
   logic            next_overflow;
   logic            next_underflow;
   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   logic [AW-1:0]   mem_raddr;
   logic [n-1:0]    mem_rdata;

   assign op    = decode_op(push, pop);
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // Memory mirrors every live entry, top included, so a pop can refill
   // the top register from the slot just below it (count-2).
   assign mem_raddr = AW'(count - CW'(2));

   always_comb begin
      next_count     = count;
      next_top       = dataOut;
      next_overflow  = clr_err ? 1'b0 : overflow;
      next_underflow = clr_err ? 1'b0 : underflow;
      mem_we         = 1'b0;
      mem_waddr      = AW'(count);
      case (op)
         OP_PUSH: begin
            if (full) begin
               next_overflow = 1'b1;
            end else begin
               mem_we     = 1'b1;
               next_top   = data;
               next_count = count + CW'(1);
            end
         end
         OP_POP: begin
            if (empty) begin
               next_underflow = 1'b1;
            end else begin
               next_count = count - CW'(1);
               next_top   = (count == CW'(1)) ? '0 : mem_rdata;
            end
         end
         OP_REPLACE: begin
            mem_we   = 1'b1;
            next_top = data;
            if (empty)
               next_count = CW'(1);
            else
               mem_waddr = AW'(count - CW'(1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         dataOut   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         count     <= next_count;
         dataOut   <= next_top;
         overflow  <= next_overflow;
         underflow <= next_underflow;
      end
   end

   stack_mem #(
      .n     (n),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we && !rst),
      .waddr (mem_waddr),
      .wdata (data),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_stack_register.sv
// Directed plus random check of stack_register against a queue-based LIFO model.
module tb_stack_register;

   localparam int N     = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  data = '0;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic          clr_err = 1'b0;
   logic [N-1:0]  dataOut;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic          overflow;
   logic          underflow;

   int unsigned total = 0;
   int unsigned bad   = 0;

   int   model_q[$];
   logic model_ovf = 1'b0;
   logic model_unf = 1'b0;

   always #5 clk = ~clk;

   stack_register #(
      .n     (N),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .data      (data),
      .push      (push),
      .pop       (pop),
      .clr_err   (clr_err),
      .dataOut   (dataOut),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic p, input logic po,
                             input logic c, input int d);
      if (r) begin
         model_q.delete();
         model_ovf = 1'b0;
         model_unf = 1'b0;
      end else begin
         if (c) begin
            model_ovf = 1'b0;
            model_unf = 1'b0;
         end
         if (p && !po) begin
            if (model_q.size() == DEPTH) model_ovf = 1'b1;
            else model_q.push_back(d);
         end else if (!p && po) begin
            if (model_q.size() == 0) model_unf = 1'b1;
            else void'(model_q.pop_back());
         end else if (p && po) begin
            if (model_q.size() == 0) model_q.push_back(d);
            else model_q[model_q.size()-1] = d;
         end
      end
   endtask

   task automatic do_op(input string tag, input logic r, input logic p, input logic po,
                        input logic c, input logic [N-1:0] d);
      int exp_top;
      @(negedge clk);
      rst = r; push = p; pop = po; clr_err = c; data = d;
      @(posedge clk);
      #1;
      model_step(r, p, po, c, int'(d));
      exp_top = (model_q.size() == 0) ? 0 : model_q[model_q.size()-1];
      check({tag, ".dataOut"},   32'(dataOut),   32'(exp_top));
      check({tag, ".count"},     32'(count),     32'(model_q.size()));
      check({tag, ".empty"},     32'(empty),     32'(model_q.size() == 0));
      check({tag, ".full"},      32'(full),      32'(model_q.size() == DEPTH));
      check({tag, ".overflow"},  32'(overflow),  32'(model_ovf));
      check({tag, ".underflow"}, 32'(underflow), 32'(model_unf));
   endtask

   initial begin
      // reset with a push pending
      do_op("reset0", 1, 1, 0, 0, N'($urandom));
      do_op("reset1", 1, 1, 0, 0, N'($urandom));
      check("reset.dataOut_const", 32'(dataOut), 32'h0);

      // fill and drain
      do_op("fill1", 0, 1, 0, 0, 8'h11);
      do_op("fill2", 0, 1, 0, 0, 8'h22);
      do_op("fill3", 0, 1, 0, 0, 8'h33);
      do_op("fill4", 0, 1, 0, 0, 8'h44);
      check("fill.full_const", 32'(full), 32'h1);
      do_op("drain1", 0, 0, 1, 0, 8'h00);
      check("drain1.top_const", 32'(dataOut), 32'h33);
      do_op("drain2", 0, 0, 1, 0, 8'h00);
      do_op("drain3", 0, 0, 1, 0, 8'h00);
      check("drain3.top_const", 32'(dataOut), 32'h11);
      do_op("drain4", 0, 0, 1, 0, 8'h00);

      // overflow
      do_op("ovf_fill1", 0, 1, 0, 0, 8'h11);
      do_op("ovf_fill2", 0, 1, 0, 0, 8'h22);
      do_op("ovf_fill3", 0, 1, 0, 0, 8'h33);
      do_op("ovf_fill4", 0, 1, 0, 0, 8'h44);
      do_op("ovf_push", 0, 1, 0, 0, 8'h55);
      check("ovf.top_const", 32'(dataOut), 32'h44);
      do_op("ovf_clr", 0, 0, 0, 1, 8'h00);

      // replace on full, then drain to empty
      do_op("rep_full", 0, 1, 1, 0, 8'hC4);
      do_op("rep_full_pop", 0, 0, 1, 0, 8'h00);
      do_op("drain_b1", 0, 0, 1, 0, 8'h00);
      do_op("drain_b2", 0, 0, 1, 0, 8'h00);
      do_op("drain_b3", 0, 0, 1, 0, 8'h00);

      // underflow, and new error beating clr_err
      do_op("unf_pop", 0, 0, 1, 0, 8'h00);
      do_op("unf_clr_pop", 0, 0, 1, 1, 8'h00);
      check("unf.sticky_const", 32'(underflow), 32'h1);
      do_op("unf_clr", 0, 0, 0, 1, 8'h00);

      // replace on [0x11,0x22] and on empty
      do_op("rep_a", 0, 1, 0, 0, 8'h11);
      do_op("rep_b", 0, 1, 0, 0, 8'h22);
      do_op("rep_mid", 0, 1, 1, 0, 8'hAA);
      do_op("rep_push", 0, 1, 0, 0, 8'hBB);
      do_op("rep_pop1", 0, 0, 1, 0, 8'h00);
      check("rep.top_const", 32'(dataOut), 32'hAA);
      do_op("rep_pop2", 0, 0, 1, 0, 8'h00);
      do_op("rep_pop3", 0, 0, 1, 0, 8'h00);
      do_op("rep_empty", 0, 1, 1, 0, 8'h77);
      check("rep_empty.top_const", 32'(dataOut), 32'h77);

      // reset mid-operation
      do_op("mid_a", 0, 1, 0, 0, 8'h01);
      do_op("mid_b", 0, 1, 0, 0, 8'h02);
      do_op("mid_rst", 1, 1, 0, 0, 8'h99);
      do_op("mid_push", 0, 1, 0, 0, 8'h12);
      check("mid.top_const", 32'(dataOut), 32'h12);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         do_op("rand", ($urandom_range(0, 40) == 0), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0), N'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stack_register.md
# stack_register

Parametrised LIFO register stack for the 8-bit CPU datapath: generalises the single load/clear register to DEPTH entries with push/pop, full/empty status and sticky error flags. Sits on the bus beside the program counter and provides return-address/data storage for CALL/RET and PUSH/POP microcode. `dataOut` always presents the registered top of stack, so the bus driver needs no extra read cycle.

## Interface

**Parameters**
- `n`, default 8: entry width in bits; legal range ≥1.
- `DEPTH`, default 4: number of entries; legal range ≥2.

**Ports**
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `data`, in, n: value to push.
- `push`, in, 1: push request, sampled at the rising edge.
- `pop`, in, 1: pop request, sampled at the rising edge.
- `clr_err`, in, 1: synchronous clear of the sticky error flags.
- `dataOut`, out, n: current top of stack; 0 when empty.
- `count`, out, $clog2(DEPTH+1): number of valid entries.
- `empty`, out, 1: `count == 0`.
- `full`, out, 1: `count == DEPTH`.
- `overflow`, out, 1: sticky flag; a push was dropped.
- `underflow`, out, 1: sticky flag; a pop was dropped.

## Operation

- The operation is decoded each edge from `{push,pop}`:
  - 00 = NOP.
  - 10 = PUSH.
  - 01 = POP.
  - 11 = REPLACE.
- **PUSH, not full:** `data` becomes the new top; `count` increments by 1.
- **PUSH, full:** dropped; contents and `count` are unchanged; `overflow` is set to 1.
- **POP, non-empty:** the top is discarded; `count` decrements by 1; `dataOut` becomes the previous entry below, or 0 if the stack is now empty.
- **POP, empty:** dropped; `underflow` is set to 1.
- **REPLACE, non-empty (including full):** the top is overwritten with `data`; `count` is unchanged; no flag is set.
- **REPLACE, empty:** behaves as PUSH; `count` becomes 1; `underflow` is not set.
- **Error flags:**
  - The flags are sticky until `rst` or `clr_err`.
  - If `clr_err` and a new error occur in the same cycle, the new error wins and the flag reads 1.
- **Storage:**
  - Entries below the top are never visible on `dataOut` until popped into the top position.
  - Stale entries above `count` are don't-care.
- **Reset priority:** `rst` has priority over every other input.
  - It forces `count`=0, `dataOut`=0, `empty`=1, `full`=0, `overflow`=0 and `underflow`=0.
  - Memory contents are not cleared.
- **Reset mid-operation:** a push or pop in the same cycle as `rst` is discarded entirely.

## Timing

- Every output is registered or a pure decode of registered `count`; there are no combinational paths from inputs to outputs.
- **Latency:** an operation sampled at edge k is reflected on all outputs immediately after edge k (one-cycle latency).
- Back-to-back operations every cycle are supported with no stall.
- **Full path:** `full` asserts in the same cycle `count` reaches DEPTH, and the next PUSH is already dropped.
- **Empty path:** `empty` asserts in the same cycle `count` reaches 0, and the next POP is already dropped.

## Structure

- **Shared package `stack_pkg`:**
  - the `stack_op_t` enum {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE};
  - a function `decode_op(push, pop)`.
- **Sub-module `stack_mem`:**
  - DEPTH×n array with one synchronous write port and one asynchronous read port.
  - Addressed by `count` for writes and `count-2` for the read that refills the top after a pop.
- **Top level `stack_register`:**
  - holds the top-of-stack register, the `count` register, the flag registers and the op decode.

## Test plan

Scenarios use n=8, DEPTH=4.

1. **Reset:** drive random `data` with push=1 and `rst`=1 for 2 cycles → `count`=0, `dataOut`=0x00, `empty`=1, `full`=0, `overflow`=0, `underflow`=0.
2. **Fill and drain:**
   - Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles → `dataOut` reads 0x11, 0x22, 0x33, 0x44 and `full`=1 after the 4th push.
   - Then pop 4 times → `dataOut` reads 0x33, 0x22, 0x11, 0x00 and `empty`=1.
3. **Overflow:**
   - From full (top 0x44), push 0x55 → `dataOut`=0x44, `count`=4, `overflow`=1.
   - Assert `clr_err` → `overflow`=0.
4. **Underflow:**
   - From empty, pop → `underflow`=1, `count`=0.
   - Then assert `clr_err` and pop together → `underflow` stays 1.
5. **REPLACE:**
   - With stack [0x11, 0x22], push=pop=1, `data`=0xAA → `count`=2, `dataOut`=0xAA; a following pop → `dataOut`=0x11.
   - From empty, REPLACE with 0x77 → `count`=1, `dataOut`=0x77, `underflow`=0.
6. **Reset mid-operation:** with `count`=3, assert `rst` together with push of 0x99 → `count`=0, `dataOut`=0x00; on the next cycle push 0x12 → `dataOut`=0x12, `count`=1.
